seg7_scan_driver: RTL

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 130 +++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with a shadow digit register.
// Also provides leading-zero suppression, per-digit blink and a dead-time slot at the start of each digit.
module seg7_scan_driver #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_SCANS = 64
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   bcd,
   input  logic                  load,
   input  logic                  lz_en,
   input  logic [DIGITS-1:0]     blink_mask,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an,
   output logic                  scan_done
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

   localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SCANS - 1);
   localparam logic [6:0]    SEG_BLANK  = 7'b1111111;

   logic [CW-1:0]         r_cnt;
   logic [IW-1:0]         r_idx;
   logic [BW-1:0]         r_blink_cnt;
   logic                  r_phase;
   logic [4*DIGITS-1:0]   r_shadow;
   logic [6:0]            r_seg;
   logic [DIGITS-1:0]     r_an;
   logic                  r_scan_done;

   logic                  w_tick;
   logic                  w_wrap;
   logic [3:0]            w_digit;
   logic                  w_upper_zero;
   logic                  w_blank;
   logic [6:0]            w_seg;
   logic [DIGITS-1:0]     w_an;

   function automatic logic [6:0] seg_code(input logic [3:0] code);
      logic [6:0] s;
      case (code)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         4'd10:   s = 7'b1111111;
         4'd11:   s = 7'b1000110;
         4'd12:   s = 7'b0101011;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   // Next-output decode from the current scan position, shadow digits and display controls.
   always_comb begin
      w_tick       = (r_cnt == CNT_LAST);
      w_wrap       = w_tick && (r_idx == IDX_LAST);
      w_digit      = r_shadow[r_idx*4 +: 4];
      w_upper_zero = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if ((i >= int'(r_idx)) && (r_shadow[i*4 +: 4] != 4'd0)) begin
            w_upper_zero = 1'b0;
         end else begin
            w_upper_zero = w_upper_zero;
         end
      end
      // Digit 0 is never suppressed, so a value of zero still shows one '0'.
      w_blank = (!r_phase && blink_mask[r_idx]) ||
                (lz_en && (r_idx != IW'(0)) && w_upper_zero);
      if (w_blank) begin
         w_seg = SEG_BLANK;
      end else begin
         w_seg = seg_code(w_digit);
      end
      // First cycle of every slot is dead time so ghosting cannot bleed between digits.
      for (int i = 0; i < DIGITS; i++) begin
         w_an[i] = !((r_cnt != CW'(0)) && (int'(r_idx) == i));
      end
   end

   // Scan position, blink phase, shadow register and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt       <= CW'(0);
         r_idx       <= IW'(0);
         r_blink_cnt <= BW'(0);
         r_phase     <= 1'b1;
         r_shadow    <= {DIGITS{4'hA}};
         r_seg       <= SEG_BLANK;
         r_an        <= {DIGITS{1'b1}};
         r_scan_done <= 1'b0;
      end else begin
         r_cnt <= w_tick ? CW'(0) : r_cnt + CW'(1);
         if (w_tick) begin
            r_idx <= w_wrap ? IW'(0) : r_idx + IW'(1);
         end
         if (w_wrap) begin
            if (r_blink_cnt == BLINK_LAST) begin
               r_blink_cnt <= BW'(0);
               r_phase     <= ~r_phase;
            end else begin
               r_blink_cnt <= r_blink_cnt + BW'(1);
            end
         end
         if (load) begin
            r_shadow <= bcd;
         end
         r_seg       <= w_seg;
         r_an        <= w_an;
         r_scan_done <= w_wrap;
      end
   end

   assign seg       = r_seg;
   assign an        = r_an;
   assign scan_done = r_scan_done;

endmodule
